// File: rtl/rx_huge_page_scheduler.sv
// Hands out host write addresses inside the two driver-owned RX huge pages, alternating
// between them. A page is returned to the driver when it is full, when a packet will not fit, or when it sits idle too long.
module rx_huge_page_scheduler #(
    parameter int unsigned HUGE_PAGE_SIZE = 2097152,
    parameter int unsigned TIMEOUT_CYCLES = 15625
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic [63:0] huge_page_addr_1,
    input  logic [63:0] huge_page_addr_2,
    input  logic        huge_page_status_1,
    input  logic        huge_page_status_2,
    output logic        huge_page_free_1,
    output logic        huge_page_free_2,
    input  logic        wr_req,
    input  logic [13:0] wr_len,
    output logic        wr_gnt,
    output logic [63:0] wr_addr,
    input  logic        wr_done,
    output logic        closed_valid,
    output logic        closed_page,
    output logic [31:0] closed_bytes
);

    localparam int OFF_W = $clog2(HUGE_PAGE_SIZE) + 1;
    localparam int SUM_W = ((OFF_W > 15) ? OFF_W : 15) + 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SUM_W-1:0] PAGE_BYTES = SUM_W'(HUGE_PAGE_SIZE);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_OPEN,
        S_BUSY,
        S_CLOSE
    } state_e;

    state_e             state_q, state_d;
    logic               cur_q, cur_d;
    logic [63:0]        base_q, base_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic               wr_gnt_q, wr_gnt_d;
    logic [63:0]        wr_addr_q, wr_addr_d;
    logic               free_1_q, free_1_d;
    logic               free_2_q, free_2_d;
    logic               closed_valid_q, closed_valid_d;
    logic               closed_page_q, closed_page_d;
    logic [31:0]        closed_bytes_q, closed_bytes_d;

    logic [14:0]        len_r;
    logic [SUM_W-1:0]   fill_sum;
    logic               fits;
    logic               page_full;
    logic               page_used;
    logic               idle_expired;
    logic               cur_status;
    logic [63:0]        cur_addr;

    // Sums are one bit wider than either operand so a 16 KiB packet on a nearly full page cannot wrap.
    assign len_r        = ({1'b0, wr_len} + 15'd7) & 15'h7ff8;
    assign fill_sum     = SUM_W'(offset_q) + SUM_W'(len_r);
    assign fits         = (fill_sum <= PAGE_BYTES);
    assign page_full    = (SUM_W'(offset_q) == PAGE_BYTES);
    assign page_used    = (offset_q != '0);
    assign idle_expired = page_used && (tmo_cnt_q == TMO_LAST);
    assign cur_status   = cur_q ? huge_page_status_2 : huge_page_status_1;
    assign cur_addr     = cur_q ? huge_page_addr_2   : huge_page_addr_1;

    // NOTE: asynchronous reset drops the open page outright; no free pulse is issued for it.
    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_WAIT: begin
                if (cur_status) state_d = S_OPEN;
            end
            S_OPEN: begin
                if (wr_req) begin
                    // A packet larger than an empty page stalls; an empty page is never closed.
                    if (fits)           state_d = S_BUSY;
                    else if (page_used) state_d = S_CLOSE;
                end else if (idle_expired) begin
                    state_d = S_CLOSE;
                end
            end
            S_BUSY: begin
                if (wr_done) state_d = page_full ? S_CLOSE : S_OPEN;
            end
            S_CLOSE: begin
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        cur_d          = cur_q;
        base_d         = base_q;
        offset_d       = offset_q;
        tmo_cnt_d      = tmo_cnt_q;
        wr_gnt_d       = 1'b0;
        wr_addr_d      = wr_addr_q;
        free_1_d       = 1'b0;
        free_2_d       = 1'b0;
        closed_valid_d = 1'b0;
        closed_page_d  = closed_page_q;
        closed_bytes_d = closed_bytes_q;

        unique case (state_q)
            S_WAIT: begin
                if (cur_status) begin
                    base_d    = cur_addr;
                    offset_d  = '0;
                    tmo_cnt_d = '0;
                end
            end
            S_OPEN: begin
                if (wr_req && fits) begin
                    wr_gnt_d  = 1'b1;
                    wr_addr_d = base_q + 64'(offset_q);
                    offset_d  = OFF_W'(fill_sum);
                    tmo_cnt_d = '0;
                end else if (!wr_req && page_used && !idle_expired) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_CLOSE: begin
                cur_d     = ~cur_q;
                offset_d  = '0;
                tmo_cnt_d = '0;
            end
            default: ;
        endcase

        // Close outputs are launched on the transition so they coincide with the CLOSE cycle.
        if (state_d == S_CLOSE) begin
            free_1_d       = ~cur_q;
            free_2_d       = cur_q;
            closed_valid_d = 1'b1;
            closed_page_d  = cur_q;
            closed_bytes_d = 32'(offset_q);
        end
    end

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            cur_q          <= 1'b0;
            base_q         <= '0;
            offset_q       <= '0;
            tmo_cnt_q      <= '0;
            wr_gnt_q       <= 1'b0;
            wr_addr_q      <= '0;
            free_1_q       <= 1'b0;
            free_2_q       <= 1'b0;
            closed_valid_q <= 1'b0;
            closed_page_q  <= 1'b0;
            closed_bytes_q <= '0;
        end else begin
            cur_q          <= cur_d;
            base_q         <= base_d;
            offset_q       <= offset_d;
            tmo_cnt_q      <= tmo_cnt_d;
            wr_gnt_q       <= wr_gnt_d;
            wr_addr_q      <= wr_addr_d;
            free_1_q       <= free_1_d;
            free_2_q       <= free_2_d;
            closed_valid_q <= closed_valid_d;
            closed_page_q  <= closed_page_d;
            closed_bytes_q <= closed_bytes_d;
        end
    end

    assign wr_gnt           = wr_gnt_q;
    assign wr_addr          = wr_addr_q;
    assign huge_page_free_1 = free_1_q;
    assign huge_page_free_2 = free_2_q;
    assign closed_valid     = closed_valid_q;
    assign closed_page      = closed_page_q;
    assign closed_bytes     = closed_bytes_q;

endmodule

// File: tb/tb_rx_huge_page_scheduler.sv
// Directed bench for rx_huge_page_scheduler with a 4 KiB page and a 16-cycle idle timeout.
// It covers grants, exact fill, non-fit close, timeout, page starvation and reset while busy.
module tb_rx_huge_page_scheduler;

    logic        trn_clk = 1'b0;
    logic        reset;
    logic [63:0] huge_page_addr_1;
    logic [63:0] huge_page_addr_2;
    logic        huge_page_status_1;
    logic        huge_page_status_2;
    logic        huge_page_free_1;
    logic        huge_page_free_2;
    logic        wr_req;
    logic [13:0] wr_len;
    logic        wr_gnt;
    logic [63:0] wr_addr;
    logic        wr_done;
    logic        closed_valid;
    logic        closed_page;
    logic [31:0] closed_bytes;

    localparam logic [63:0] ADDR_1 = 64'h0000_0001_0000_0000;
    localparam logic [63:0] ADDR_2 = 64'h0000_0002_0000_0000;

    rx_huge_page_scheduler #(
        .HUGE_PAGE_SIZE(4096),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .trn_clk            (trn_clk),
        .reset              (reset),
        .huge_page_addr_1   (huge_page_addr_1),
        .huge_page_addr_2   (huge_page_addr_2),
        .huge_page_status_1 (huge_page_status_1),
        .huge_page_status_2 (huge_page_status_2),
        .huge_page_free_1   (huge_page_free_1),
        .huge_page_free_2   (huge_page_free_2),
        .wr_req             (wr_req),
        .wr_len             (wr_len),
        .wr_gnt             (wr_gnt),
        .wr_addr            (wr_addr),
        .wr_done            (wr_done),
        .closed_valid       (closed_valid),
        .closed_page        (closed_page),
        .closed_bytes       (closed_bytes)
    );

    always #5 trn_clk = ~trn_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Event counters sampled mid-cycle, so pulses landing inside a task are not missed.
    int          close_cnt = 0;
    int          free1_cnt = 0;
    int          free2_cnt = 0;
    int          gnt_cnt   = 0;
    logic        last_page;
    logic [31:0] last_bytes;

    always @(negedge trn_clk) begin
        if (closed_valid) begin
            close_cnt  = close_cnt + 1;
            last_page  = closed_page;
            last_bytes = closed_bytes;
        end
        if (huge_page_free_1) free1_cnt = free1_cnt + 1;
        if (huge_page_free_2) free2_cnt = free2_cnt + 1;
        if (wr_gnt)           gnt_cnt   = gnt_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge trn_clk);
        #1;
    endtask

    task automatic do_reset;
        reset              = 1'b1;
        wr_req             = 1'b0;
        wr_done            = 1'b0;
        wr_len             = '0;
        huge_page_status_1 = 1'b0;
        huge_page_status_2 = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Raise a request and wait (bounded) for its grant; ticks counts edges until wr_gnt is seen.
    task automatic do_grant(input string tag, input logic [13:0] len, input logic [63:0] exp_addr,
                            output int ticks);
        wr_len = len;
        wr_req = 1'b1;
        ticks  = 0;
        do begin
            tick();
            ticks++;
        end while (!wr_gnt && ticks < 100);
        check({tag, "_addr"}, wr_addr, exp_addr);
    endtask

    // Complete the DMA at once; the requester drops wr_req a cycle after seeing the grant.
    task automatic finish_req(input string tag);
        wr_done = 1'b1;
        tick();
        wr_req  = 1'b0;
        wr_done = 1'b0;
        tick();
        check({tag, "_no_regrant"}, wr_gnt, 1'b0);
    endtask

    initial begin
        int t;
        int c0, f1, f2, g0;

        huge_page_addr_1 = ADDR_1;
        huge_page_addr_2 = ADDR_2;
        do_reset();

        check("rst_gnt",    wr_gnt, 1'b0);
        check("rst_addr",   wr_addr, 64'h0);
        check("rst_free",   {huge_page_free_1, huge_page_free_2}, 2'b00);
        check("rst_cvalid", closed_valid, 1'b0);
        check("rst_cpage",  closed_page, 1'b0);
        check("rst_cbytes", closed_bytes, 32'h0);

        // Basic grants; 60 rounds to 64, 1514 to 1520, then idle timeout closes at 0x630.
        huge_page_status_1 = 1'b1;
        do_grant("basic0", 14'd60, ADDR_1, t);
        check("basic0_latency", t, 2);
        finish_req("basic0");
        do_grant("basic1", 14'd1514, ADDR_1 + 64'h40, t);
        finish_req("basic1");
        t = 1;
        do begin
            tick();
            t++;
        end while (!closed_valid && t < 100);
        check("tmo_cycles",  t, 16);
        check("tmo_bytes",   closed_bytes, 32'h630);
        check("tmo_page",    closed_page, 1'b0);
        check("tmo_free",    {huge_page_free_1, huge_page_free_2}, 2'b10);

        // Empty page never times out.
        do_reset();
        huge_page_status_1 = 1'b1;
        c0 = close_cnt;
        repeat (1000) tick();
        check("idle_no_close", close_cnt - c0, 0);

        // Exact fill with four 1 KiB packets, then the next packet lands in page 2.
        do_reset();
        huge_page_status_1 = 1'b1;
        c0 = close_cnt;
        f1 = free1_cnt;
        for (int i = 0; i < 4; i++) begin
            do_grant("fill", 14'd1024, ADDR_1 + 64'(i * 1024), t);
            finish_req("fill");
        end
        check("fill_close_cnt", close_cnt - c0, 1);
        check("fill_free1_cnt", free1_cnt - f1, 1);
        check("fill_bytes",     last_bytes, 32'd4096);
        check("fill_page",      last_page, 1'b0);
        huge_page_status_2 = 1'b1;
        do_grant("fill_p2", 14'd1024, ADDR_2, t);
        finish_req("fill_p2");

        // Non-fit close: 4000 then 200; the 200-byte packet is served at page 2 base.
        do_reset();
        huge_page_status_1 = 1'b1;
        huge_page_status_2 = 1'b1;
        c0 = close_cnt;
        f2 = free2_cnt;
        do_grant("nofit0", 14'd4000, ADDR_1, t);
        finish_req("nofit0");
        do_grant("nofit1", 14'd200, ADDR_2, t);
        check("nofit_latency", t, 4);
        check("nofit_close_cnt", close_cnt - c0, 1);
        check("nofit_bytes",     last_bytes, 32'd4000);
        check("nofit_page",      last_page, 1'b0);
        check("nofit_free2_cnt", free2_cnt - f2, 0);
        finish_req("nofit1");

        // Page starvation: page 2 not ready, request held with no grant.
        do_reset();
        huge_page_status_1 = 1'b1;
        do_grant("starve0", 14'd4000, ADDR_1, t);
        finish_req("starve0");
        wr_len = 14'd200;
        wr_req = 1'b1;
        g0 = gnt_cnt;
        repeat (50) tick();
        check("starve_no_gnt", gnt_cnt - g0, 0);
        huge_page_status_2 = 1'b1;
        do_grant("starve1", 14'd200, ADDR_2, t);
        check("starve_latency", t, 2);
        finish_req("starve1");

        // Reset during BUSY: outputs clear at once, no free pulse, fresh page 1 afterwards.
        do_reset();
        huge_page_status_1 = 1'b1;
        do_grant("rstmid0", 14'd64, ADDR_1, t);
        f1 = free1_cnt + free2_cnt;
        reset = 1'b1;
        #1;
        check("rstmid_gnt",    wr_gnt, 1'b0);
        check("rstmid_addr",   wr_addr, 64'h0);
        check("rstmid_cvalid", closed_valid, 1'b0);
        check("rstmid_free",   {huge_page_free_1, huge_page_free_2}, 2'b00);
        wr_req = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        huge_page_addr_1 = 64'h0000_0003_0000_1000;
        do_grant("rstmid1", 14'd64, 64'h0000_0003_0000_1000, t);
        check("rstmid_latency", t, 2);
        check("rstmid_no_free", free1_cnt + free2_cnt - f1, 0);
        finish_req("rstmid1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
